// File: rtl/tc_kacc_pkg.sv
// rtl/tc_kacc_pkg.sv - shared constants and types for the fp16 Kulisch dot-product engine
package tc_kacc_pkg;

  localparam int FP_EWIDTH   = 5;
  localparam int FP_MWIDTH   = 10;
  localparam int FP_BIAS     = 15;
  localparam int ACC_LSB_EXP = -48;

  localparam int FLAG_NAN     = 0;
  localparam int FLAG_INF_POS = 1;
  localparam int FLAG_INF_NEG = 2;
  localparam int FLAG_OVF     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/tc_kacc_lane.sv
// rtl/tc_kacc_lane.sv - one lane: fp16 decode, exact product, special detect (S1 register)
// and alignment of the registered product onto the accumulator's fixed-point grid.
module tc_kacc_lane
  import tc_kacc_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int EWIDTH = FP_EWIDTH,
  parameter int MWIDTH = FP_MWIDTH,
  parameter int BIAS   = FP_BIAS,
  parameter int AWIDTH = 91
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DWIDTH-1:0] i_a,
  input  logic [DWIDTH-1:0] i_b,
  output logic [AWIDTH-1:0] o_term,
  output logic              o_nan,
  output logic              o_inf_pos,
  output logic              o_inf_neg
);

  localparam int SW        = EWIDTH + 1;
  localparam int PW        = 2 * (MWIDTH + 1);
  // Product LSB weight is 2^(ea+eb-2*BIAS-2*MWIDTH); rebase onto the 2^ACC_LSB_EXP grid.
  localparam int SHIFT_OFS = 2 * BIAS + 2 * MWIDTH + ACC_LSB_EXP;

  logic [EWIDTH-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [MWIDTH-1:0] w_ma, w_mb;
  logic [MWIDTH:0]   w_sig_a, w_sig_b;
  logic [PW-1:0]     w_prod;
  logic [SW-1:0]     w_shift;
  logic              w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic              w_nan, w_inf;

  assign w_ea = i_a[MWIDTH +: EWIDTH];
  assign w_eb = i_b[MWIDTH +: EWIDTH];
  assign w_ma = i_a[MWIDTH-1:0];
  assign w_mb = i_b[MWIDTH-1:0];

  assign w_ea_eff = (w_ea == '0) ? EWIDTH'(1) : w_ea;
  assign w_eb_eff = (w_eb == '0) ? EWIDTH'(1) : w_eb;
  assign w_sig_a  = {|w_ea, w_ma};
  assign w_sig_b  = {|w_eb, w_mb};
  assign w_prod   = PW'(w_sig_a) * PW'(w_sig_b);
  assign w_shift  = {1'b0, w_ea_eff} + {1'b0, w_eb_eff} - SW'(SHIFT_OFS);

  assign w_a_max  = &w_ea;
  assign w_b_max  = &w_eb;
  assign w_a_nan  = w_a_max && (w_ma != '0);
  assign w_b_nan  = w_b_max && (w_mb != '0);
  assign w_a_inf  = w_a_max && (w_ma == '0);
  assign w_b_inf  = w_b_max && (w_mb == '0);
  assign w_a_zero = (w_ea == '0) && (w_ma == '0);
  assign w_b_zero = (w_eb == '0) && (w_mb == '0);
  assign w_nan    = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
  assign w_inf    = (w_a_inf || w_b_inf) && !w_nan;

  logic          r_sign, r_nan, r_inf;
  logic [PW-1:0] r_prod;
  logic [SW-1:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign  <= 1'b0;
      r_nan   <= 1'b0;
      r_inf   <= 1'b0;
      r_prod  <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_sign  <= i_a[DWIDTH-1] ^ i_b[DWIDTH-1];
      r_nan   <= w_nan;
      r_inf   <= w_inf;
      r_prod  <= (w_a_max || w_b_max) ? '0 : w_prod;
      r_shift <= w_shift;
    end
  end

  logic [AWIDTH-1:0] w_mag;

  assign w_mag     = AWIDTH'(r_prod) << r_shift;
  assign o_term    = r_sign ? -w_mag : w_mag;
  assign o_nan     = r_nan;
  assign o_inf_pos = r_inf && !r_sign;
  assign o_inf_neg = r_inf && r_sign;

endmodule

// File: rtl/tensor_core_dot_kacc.sv
// rtl/tensor_core_dot_kacc.sv - streaming LANES-wide fp16 dot product with exact wide accumulation.
// Optional TC_KACC_INIT_EN adds s_init/s_init_acc for accumulator preload.
module tensor_core_dot_kacc
  import tc_kacc_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DWIDTH = 16,
  parameter int EWIDTH = FP_EWIDTH,
  parameter int MWIDTH = FP_MWIDTH,
  parameter int BIAS   = FP_BIAS,
  parameter int AWIDTH = 91
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [LANES*DWIDTH-1:0] s_a,
  input  logic [LANES*DWIDTH-1:0] s_b,
`ifdef TC_KACC_INIT_EN
  input  logic                    s_init,
  input  logic [AWIDTH-1:0]       s_init_acc,
`endif
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [AWIDTH-1:0]       m_acc,
  output logic [3:0]              m_flags
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic       w_accept, w_out_take;

  assign s_ready    = (r_state == ACCUM);
  assign m_valid    = (r_state == OUT);
  assign w_accept   = s_valid && s_ready;
  assign w_out_take = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // DRAIN counts two edges after the last beat, then one more edge lands in OUT
  // once the final beat has been folded into the accumulator.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE:  w_state_nxt = ACCUM;
      ACCUM: begin
        if (w_accept && s_last) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (r_cnt == 2'd2) w_state_nxt = OUT;
        else               w_cnt_nxt   = r_cnt + 2'd1;
      end
      OUT:   if (m_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = IDLE;
    endcase
  end

  logic [AWIDTH-1:0] w_term [LANES];
  logic [LANES-1:0]  w_lane_nan, w_lane_inf_pos, w_lane_inf_neg;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tc_kacc_lane #(
      .DWIDTH (DWIDTH),
      .EWIDTH (EWIDTH),
      .MWIDTH (MWIDTH),
      .BIAS   (BIAS),
      .AWIDTH (AWIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_accept),
      .i_a       (s_a[g*DWIDTH +: DWIDTH]),
      .i_b       (s_b[g*DWIDTH +: DWIDTH]),
      .o_term    (w_term[g]),
      .o_nan     (w_lane_nan[g]),
      .o_inf_pos (w_lane_inf_pos[g]),
      .o_inf_neg (w_lane_inf_neg[g])
    );
  end

  logic [AWIDTH-1:0] w_tree;
  logic [3:0]        w_beat_fl;

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) w_tree = w_tree + w_term[i];
  end

  always_comb begin
    w_beat_fl               = '0;
    w_beat_fl[FLAG_NAN]     = |w_lane_nan;
    w_beat_fl[FLAG_INF_POS] = |w_lane_inf_pos;
    w_beat_fl[FLAG_INF_NEG] = |w_lane_inf_neg;
  end

  logic              r_s1_valid, r_s2_valid;
  logic [AWIDTH-1:0] r_s2_sum;
  logic [3:0]        r_s2_fl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_fl    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum <= w_tree;
        r_s2_fl  <= w_beat_fl;
      end
    end
  end

  logic [AWIDTH-1:0] r_acc, w_base, w_sum;
  logic [3:0]        r_flags, w_add_fl;
  logic              w_ovf;

`ifdef TC_KACC_INIT_EN
  logic              r_s1_init, r_s2_init;
  logic [AWIDTH-1:0] r_s1_init_acc, r_s2_init_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_init     <= 1'b0;
      r_s2_init     <= 1'b0;
      r_s1_init_acc <= '0;
      r_s2_init_acc <= '0;
    end else begin
      if (w_accept) begin
        r_s1_init     <= s_init;
        r_s1_init_acc <= s_init_acc;
      end
      if (r_s1_valid) begin
        r_s2_init     <= r_s1_init;
        r_s2_init_acc <= r_s1_init_acc;
      end
    end
  end

  assign w_base = r_s2_init ? r_s2_init_acc : r_acc;
`else
  assign w_base = r_acc;
`endif

  assign w_sum = w_base + r_s2_sum;
  assign w_ovf = (w_base[AWIDTH-1] == r_s2_sum[AWIDTH-1]) && (w_sum[AWIDTH-1] != w_base[AWIDTH-1]);

  always_comb begin
    w_add_fl           = r_s2_fl;
    w_add_fl[FLAG_OVF] = w_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (w_out_take) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (r_s2_valid) begin
      r_acc   <= w_sum;
      r_flags <= r_flags | w_add_fl;
    end
  end

  assign m_acc   = r_acc;
  assign m_flags = r_flags;

endmodule

// File: tb/tb_tensor_core_dot_kacc.sv
// tb/tb_tensor_core_dot_kacc.sv - directed bench with an exact arithmetic model and per-cycle result compare
module tb_tensor_core_dot_kacc;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AW    = 91;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid, s_ready, s_last;
  logic [LANES*DW-1:0] s_a, s_b;
  logic               m_valid, m_ready;
  logic [AW-1:0]      m_acc;
  logic [3:0]         m_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_edge = 0;

  typedef struct {
    logic [AW-1:0] acc;
    logic [3:0]    fl;
  } res_t;

  res_t          exp_q[$];
  logic [AW-1:0] mdl_acc = '0;
  logic [3:0]    mdl_fl  = '0;

  tensor_core_dot_kacc #(.LANES(LANES), .AWIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_a     (s_a),
    .s_b     (s_b),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_acc   (m_acc),
    .m_flags (m_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Exact value of one fp16 product in units of 2^-48, from the fp16 value definition.
  function automatic void lane_model(input logic [15:0] a, b, output logic [127:0] term,
                                     output logic nan, output logic inf);
    logic [4:0]   ea, eb;
    logic [9:0]   fa, fb;
    logic [127:0] ma, mb, mag;
    int           xa, xb;
    logic         an, bn, ai, bi, az, bz;
    ea = a[14:10]; eb = b[14:10]; fa = a[9:0]; fb = b[9:0];
    an = (ea == 5'h1f) && (fa != 0);  bn = (eb == 5'h1f) && (fb != 0);
    ai = (ea == 5'h1f) && (fa == 0);  bi = (eb == 5'h1f) && (fb == 0);
    az = (ea == 0) && (fa == 0);      bz = (eb == 0) && (fb == 0);
    ma = (ea == 0) ? 128'(fa) : 128'(fa) + 128'd1024;
    mb = (eb == 0) ? 128'(fb) : 128'(fb) + 128'd1024;
    xa = (ea == 0) ? -24 : int'(ea) - 25;
    xb = (eb == 0) ? -24 : int'(eb) - 25;
    term = '0; nan = 1'b0; inf = 1'b0;
    if (an || bn || (ai && bz) || (bi && az)) nan = 1'b1;
    else if (ai || bi) inf = 1'b1;
    else begin
      mag  = (ma * mb) << (xa + xb + 48);
      term = (a[15] ^ b[15]) ? -mag : mag;
    end
  endfunction

  task automatic model_beat(input logic [63:0] a, b, input bit last);
    logic [127:0] sum, t;
    logic [AW-1:0] s91, nw;
    logic nan, inf;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_model(a[i*16 +: 16], b[i*16 +: 16], t, nan, inf);
      sum = sum + t;
      if (nan) mdl_fl[0] = 1'b1;
      if (inf) begin
        if (a[i*16+15] ^ b[i*16+15]) mdl_fl[2] = 1'b1;
        else                         mdl_fl[1] = 1'b1;
      end
    end
    s91 = sum[AW-1:0];
    nw  = mdl_acc + s91;
    if ((mdl_acc[AW-1] == s91[AW-1]) && (nw[AW-1] != mdl_acc[AW-1])) mdl_fl[3] = 1'b1;
    mdl_acc = nw;
    if (last) begin
      exp_q.push_back('{acc: mdl_acc, fl: mdl_fl});
      mdl_acc = '0;
      mdl_fl  = '0;
    end
  endtask

  task automatic send(input logic [63:0] a, b, input bit last);
    int t = 0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 50);
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: s_ready stayed 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    last_edge = cyc;
    model_beat(a, b, last);
  endtask

  task automatic finish_dp(input string name, input logic [AW-1:0] exp_acc, input logic [3:0] exp_fl,
                           input int hold, input bit chk_lat);
    int t = 0;
    while (!m_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!m_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: m_valid stayed 0 expected 1", name);
      return;
    end
    if (chk_lat) chk({name, "_latency"}, 128'(cyc - last_edge), 128'd3);
    chk({name, "_acc"}, m_acc, exp_acc);
    chk({name, "_flags"}, m_flags, exp_fl);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, m_valid, 1);
      chk({name, "_hold_sready"}, s_ready, 0);
      chk({name, "_hold_acc"}, m_acc, exp_acc);
      chk({name, "_hold_flags"}, m_flags, exp_fl);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: m_valid=1 with no result expected");
      end else begin
        chk("model_acc", m_acc, exp_q[0].acc);
        chk("model_flags", m_flags, exp_q[0].fl);
        if (m_ready) exp_q.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] one_lsb48, mix;
    one_lsb48 = AW'(1) << 48;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
    #3;
    chk("rst_sready", s_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_acc", m_acc, 0);
    chk("rst_flags", m_flags, 0);
    @(posedge clk); #1; rst = 1'b0;

    send(pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 1);
    finish_dp("ones", AW'(128'h4_0000_0000_0000), 4'b0000, 0, 1);

    send(pk(16'h0001, 16'hBC00, 16'h0000, 16'h0000), pk(16'h0001, 16'h3C00, 16'h0000, 16'h0000), 1);
    finish_dp("sign_tiny", AW'(1) - one_lsb48, 4'b0000, 0, 1);

    send(pk(16'h7BFF, 0, 0, 0), pk(16'h7BFF, 0, 0, 0), 0);
    send(pk(16'h0001, 0, 0, 0), pk(16'h0001, 0, 0, 0), 0);
    send(pk(16'hFBFF, 0, 0, 0), pk(16'h7BFF, 0, 0, 0), 1);
    finish_dp("multibeat", AW'(1), 4'b0000, 0, 1);

    send(pk(0, 0, 16'h7C00, 0), pk(0, 0, 16'h0000, 0), 1);
    finish_dp("inf_x_zero", AW'(0), 4'b0001, 0, 0);
    send(pk(16'hFC00, 0, 0, 0), pk(16'h3C00, 0, 0, 0), 1);
    finish_dp("neg_inf", AW'(0), 4'b0100, 0, 0);

    mix = (AW'(4) << 48) + (AW'(1) << 19) + (AW'(2047) << 29);
    send(pk(16'h4000, 16'h3800, 16'h0400, 16'h7BFF), pk(16'h4200, 16'hC400, 16'h0200, 16'h0001), 1);
    finish_dp("backpressure", mix, 4'b0000, 5, 0);
    send(pk(16'h3C00, 0, 0, 0), pk(16'h3C00, 0, 0, 0), 1);
    finish_dp("after_bp", one_lsb48, 4'b0000, 0, 1);

    send(pk(16'h4000, 0, 0, 0), pk(16'h4000, 0, 0, 0), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_mvalid", m_valid, 0);
    chk("mid_rst_sready", s_ready, 0);
    chk("mid_rst_acc", m_acc, 0);
    exp_q.delete();
    mdl_acc = '0; mdl_fl = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    send(pk(16'h3C00, 0, 0, 0), pk(16'h3C00, 0, 0, 0), 1);
    finish_dp("post_rst", one_lsb48, 4'b0000, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
